// File: rtl/fsm_pkg.sv
// Shared types for the sequence generator: FSM states, pattern modes and
// the Gray-code helper used when advancing the Gray sequence.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_TOGGLE = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_BIN    = 2'd2;
    localparam logic [1:0] MODE_GRAY   = 2'd3;

    // Fixed 32-bit width so callers of any WIDTH up to 32 can share it.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fsm_dwell_cnt.sv
// Dwell counter: counts run cycles and strobes step on the last cycle of
// each (dwell+1)-cycle hold, then restarts from zero.
module fsm_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               step
);

    logic [DWELL_W-1:0] cnt;

    assign step = run && (cnt == dwell);

    // Counter holds its value whenever run is low, which is what freezes it in PAUSE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == dwell) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_seq_gen.sv
// Programmable pattern generator: toggle, walking-one, binary or Gray
// sequences with per-value dwell, start/stop/pause control and config handshake.
module fsm_seq_gen
    import fsm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    output logic [WIDTH-1:0]   out,
    output logic               tick,
    output logic               wrap,
    output logic               busy
);

    state_t             state;
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [WIDTH-1:0]   bin;

    logic               cfg_fire;
    logic [1:0]         load_mode;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   run_start;
    logic [WIDTH-1:0]   bin_next;
    logic [WIDTH-1:0]   pat_next;
    logic               cnt_run;
    logic               cnt_clr;
    logic               step;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cnt_run   = (state == RUN) && en && !stop;
    assign cnt_clr   = (state == IDLE);

    fsm_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .run   (cnt_run),
        .dwell (dwell_q),
        .step  (step)
    );

    // A config taken on the start edge must already select the start value.
    always_comb begin
        load_mode = cfg_fire ? cfg_mode : mode_q;
        load_val  = (load_mode == MODE_WALK) ? WIDTH'(1) : '0;
        run_start = (mode_q == MODE_WALK) ? WIDTH'(1) : '0;
        bin_next  = bin + WIDTH'(1);
        pat_next  = '0;
        case (mode_q)
            MODE_TOGGLE: pat_next = ~out;
            MODE_WALK:   pat_next = {out[WIDTH-2:0], out[WIDTH-1]};
            MODE_BIN:    pat_next = bin_next;
            default:     pat_next = WIDTH'(bin2gray(32'(bin_next)));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= MODE_TOGGLE;
            dwell_q <= '0;
            out     <= '0;
            bin     <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        mode_q  <= cfg_mode;
                        dwell_q <= cfg_dwell;
                    end
                    if (start && !stop) begin
                        state <= RUN;
                        out   <= load_val;
                        bin   <= '0;
                    end else begin
                        out <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        out   <= '0;
                    end else if (!en) begin
                        state <= PAUSE;
                    end else if (step) begin
                        out  <= pat_next;
                        bin  <= bin_next;
                        tick <= 1'b1;
                        wrap <= (pat_next == run_start);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state <= IDLE;
                        out   <= '0;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: expected pattern values are queued when a
// run is launched and popped as each tick appears on the outputs.
module tb_fsm_seq_gen;

    localparam int WIDTH   = 4;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_mode;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               start;
    logic               stop;
    logic               en;
    logic [WIDTH-1:0]   out;
    logic               tick;
    logic               wrap;
    logic               busy;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic             wrp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fsm_seq_gen #(
        .WIDTH   (WIDTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_dwell (cfg_dwell),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .out       (out),
        .tick      (tick),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic cv, input logic [1:0] m, input logic [DWELL_W-1:0] d,
                                 input logic st, input logic sp, input logic e);
        cfg_valid = cv;
        cfg_mode  = m;
        cfg_dwell = d;
        start     = st;
        stop      = sp;
        en        = e;
    endtask

    function automatic logic [WIDTH-1:0] expValue(input logic [1:0] mode, input int k);
        logic [WIDTH-1:0] one;
        int b;
        one = 1;
        b   = k % (1 << WIDTH);
        case (mode)
            2'd0:    return (k % 2 == 1) ? '1 : '0;
            2'd1:    return one << (k % WIDTH);
            2'd2:    return WIDTH'(b);
            default: return WIDTH'(b ^ (b >> 1));
        endcase
    endfunction

    function automatic int periodOf(input logic [1:0] mode);
        case (mode)
            2'd0:    return 2;
            2'd1:    return WIDTH;
            default: return 1 << WIDTH;
        endcase
    endfunction

    // Step k is the k-th value after the start value; wrap marks a return to it.
    task automatic pushSteps(input logic [1:0] mode, input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            sb.push_back('{val: expValue(mode, k), wrp: ((k % periodOf(mode)) == 0)});
        end
    endtask

    // Waits for n ticks, expecting each after gap+1 edges, and checks against the queue.
    task automatic drainSteps(input int n, input int gap, input bit grayCheck);
        int               waited;
        logic [WIDTH-1:0] prev;
        exp_t             e;
        for (int i = 0; i < n; i++) begin
            prev   = out;
            waited = 0;
            do begin
                stepClock();
                waited++;
            end while (!tick && waited <= gap + 2);
            checkOutput("step_gap", waited, gap + 1);
            if (!tick) break;
            checkOutput("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() == 0) break;
            e = sb.pop_front();
            checkOutput("step_out", out, e.val);
            checkOutput("step_wrap", wrap, e.wrp);
            if (grayCheck) checkOutput("gray_one_bit", $countones(out ^ prev), 1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) stepClock();
        rst = 1'b0;
        stepClock();
        checkOutput("reset_out", out, 0);
        checkOutput("reset_tick", tick, 0);
        checkOutput("reset_wrap", wrap, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cfg_ready", cfg_ready, 1);

        $display("[TB] default toggle run, dwell 0");
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b1);
        stepClock();
        start = 1'b0;
        checkOutput("toggle_load_out", out, 0);
        checkOutput("toggle_load_tick", tick, 0);
        checkOutput("toggle_busy", busy, 1);
        pushSteps(2'd0, 1, 6);
        drainSteps(6, 0, 1'b0);

        $display("[TB] asynchronous reset mid-run");
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out", out, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("post_rst_out", out, 0);
            checkOutput("post_rst_busy", busy, 0);
        end

        $display("[TB] walk, dwell 2, config with start");
        applyStimulus(1'b1, 2'd1, 8'd2, 1'b1, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("walk_load_out", out, 1);
        checkOutput("walk_load_tick", tick, 0);
        pushSteps(2'd1, 1, 5);
        drainSteps(5, 2, 1'b0);
        stop = 1'b1;
        stepClock();
        stop = 1'b0;
        checkOutput("walk_stop_out", out, 0);
        checkOutput("walk_stop_busy", busy, 0);

        $display("[TB] gray, dwell 0");
        applyStimulus(1'b1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        stepClock();
        cfg_valid = 1'b0;
        checkOutput("cfg_only_busy", busy, 0);
        start = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("gray_load_out", out, 0);
        pushSteps(2'd3, 1, 16);
        drainSteps(16, 0, 1'b1);
        stop = 1'b1;
        stepClock();
        stop = 1'b0;

        $display("[TB] binary, dwell 3, pause mid-dwell");
        applyStimulus(1'b1, 2'd2, 8'd3, 1'b1, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        pushSteps(2'd2, 1, 2);
        drainSteps(2, 3, 1'b0);
        stepClock();
        checkOutput("pre_pause_tick", tick, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepClock();
            checkOutput("pause_out", out, 2);
            checkOutput("pause_tick", tick, 0);
            checkOutput("pause_busy", busy, 1);
        end
        en = 1'b1;
        // One counted cycle was spent before the pause; the resume edge plus the
        // remaining three counted cycles give a four-edge wait (gap argument 3).
        pushSteps(2'd2, 3, 1);
        drainSteps(1, 3, 1'b0);
        pushSteps(2'd2, 4, 1);
        drainSteps(1, 3, 1'b0);
        stop = 1'b1;
        stepClock();
        stop = 1'b0;

        $display("[TB] start and stop together, config held during run");
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("start_stop_busy", busy, 0);
        checkOutput("start_stop_out", out, 0);
        applyStimulus(1'b1, 2'd2, 8'd0, 1'b1, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 2'd1, 8'd5, 1'b0, 1'b0, 1'b1);
        checkOutput("run_cfg_ready", cfg_ready, 0);
        pushSteps(2'd2, 1, 6);
        drainSteps(6, 0, 1'b0);
        checkOutput("run_cfg_ready_late", cfg_ready, 0);
        stop = 1'b1;
        stepClock();
        stop = 1'b0;
        checkOutput("stopped_cfg_ready", cfg_ready, 1);
        checkOutput("stopped_out", out, 0);
        stepClock();
        cfg_valid = 1'b0;
        start = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("held_cfg_load_out", out, 1);
        pushSteps(2'd1, 1, 2);
        drainSteps(2, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_seq_gen.md
Name: fsm_seq_gen

Overview:
Parametrised successor to the team's two-state toggle FSM. Drives a WIDTH-bit output through one of four selectable sequences: toggle, walking-one, binary count, or Gray count. Each pattern value is held for a programmable dwell of (dwell+1) cycles. Adds start/stop/pause control, a config handshake, and step/wrap strobes, so it can serve as a stimulus or LED pattern source in the test fixtures.

Parameters:
WIDTH, 4, output pattern width; minimum 2.
DWELL_W, 8, width of the dwell register and the dwell counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
cfg_valid  input  1  config offer; held by the source until accepted.
cfg_ready  output  1  high only in IDLE; a transfer occurs when cfg_valid && cfg_ready.
cfg_mode  input  2  0=toggle, 1=walk, 2=binary, 3=gray.
cfg_dwell  input  DWELL_W  hold count; each value lasts cfg_dwell+1 cycles.
start  input  1  level-sampled; starts the sequence from IDLE.
stop  input  1  level-sampled; returns to IDLE from RUN or PAUSE.
en  input  1  run enable; low pauses the sequence.
out  output  WIDTH  registered pattern.
tick  output  1  one-cycle pulse, coincident with each out update.
wrap  output  1  one-cycle pulse when out returns to the start value.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, out=0, tick=0, wrap=0, busy=0, cfg_ready=1.
  - Internal counters cleared; mode=toggle, dwell=0.
  - A reset mid-run takes effect immediately, with no drain.
- States: IDLE, RUN, PAUSE. State is held in a register; next-state and output-next logic are combinational.
- Transitions:
  - IDLE -> RUN when start=1 and stop=0.
  - RUN -> PAUSE when en=0 and stop=0.
  - PAUSE -> RUN when en=1 and stop=0.
  - RUN/PAUSE -> IDLE when stop=1.
  - Stop beats start in the same cycle. Start in RUN/PAUSE is ignored.
- Config:
  - Accepted only in IDLE; latched into mode_q/dwell_q on the handshake edge.
  - A config and a start in the same cycle are both taken; the run uses the new config.
  - Outside IDLE, cfg_ready=0 and the source holds its offer.
- Start values: toggle 0...0; walk 0...01; binary 0; gray 0.
- IDLE -> RUN:
  - The next edge loads out=start value and clears cnt.
  - tick=0 and wrap=0 on that load.
- In RUN, every cycle:
  - If cnt==dwell_q: advance the pattern, cnt<=0, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Sequences:
  - toggle: all-0 / all-1 alternating, period 2.
  - walk: rotate left by 1, period WIDTH.
  - binary: bin<=bin+1, wraps at 2^WIDTH-1 -> 0, period 2^WIDTH.
  - gray: bin<=bin+1; out=bin^(bin>>1) computed on the next value and registered, period 2^WIDTH.
- wrap=1 together with tick when the new out equals the start value.
- PAUSE: out, cnt and the pattern counter are frozen; tick=0, wrap=0. Resuming continues from the frozen cnt.
- Entering IDLE: out<=0, tick<=0, wrap<=0 on the same edge.
- dwell=0: out advances every cycle in RUN; tick is high continuously.
- Counter widths are fixed: cnt is DWELL_W bits, the pattern counter is WIDTH bits. Overflow is modulo.

Decomposition:
- Package fsm_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - mode constants: MODE_TOGGLE, MODE_WALK, MODE_BIN, MODE_GRAY.
  - function bin2gray.
- One sub-module, fsm_dwell_cnt (DWELL_W), owns cnt and produces the step strobe.
  - Inputs: clk, rst, clr, run, dwell.
  - Output: step.

Test Plan:
1. rst=1 asserted mid-RUN between edges -> out=0, busy=0, cfg_ready=1 immediately, before any clk edge. After release, out stays 0 until a start is given.
2. Defaults (toggle, dwell=0), start for 1 cycle, en=1 -> out 0000,1111,0000,... changing every cycle. tick high each step; wrap every 2nd step.
3. cfg mode=walk, dwell=2, then start -> out 0001 for 3 cycles, then 0010, 0100, 1000, 0001. wrap is asserted with the 0001 step; tick once every 3 cycles.
4. mode=gray, dwell=0 -> out 0000,0001,0011,0010,0110,... through 1000, then 0000 with wrap. Exactly one bit changes per step across all 16 steps.
5. binary, dwell=3, en dropped for 5 cycles mid-dwell -> out and cnt frozen, tick=0 throughout. On resume, the step lands after the remaining dwell cycles only, for 4 RUN cycles total per value.
6. start=1 and stop=1 together in IDLE -> stays IDLE. cfg_valid held during RUN -> cfg_ready=0 and no config change. After stop, the config is accepted on the first IDLE cycle.
